// File: rtl/max_unpool_pkg.sv
// Shared types and constants for the 2x2 max-unpooling stage.
package max_unpool_pkg;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT_TOP = 2'd1,
    EMIT_BOT = 2'd2
  } state_e;

  localparam logic [1:0] IDX_00 = 2'b00;
  localparam logic [1:0] IDX_01 = 2'b01;
  localparam logic [1:0] IDX_10 = 2'b10;
  localparam logic [1:0] IDX_11 = 2'b11;

  localparam int DEF_WIDTH = 9;

  typedef struct packed {
    logic [1:0]                  idx;
    logic signed [DEF_WIDTH-1:0] data;
  } entry_t;

  // True when the stored argmax index names output position {row, col}.
  function automatic logic idx_hit(input logic [1:0] idx, input logic row, input logic col);
    return idx == {row, col};
  endfunction

endpackage

// File: rtl/unpool_row_buf.sv
// One pooled row of {idx, data} entries: one write port, one asynchronous read port.
module unpool_row_buf #(
  parameter int EW    = 11,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [EW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [EW-1:0] rdata_o
);

  logic [EW-1:0] mem_q [DEPTH];

  // Contents are never cleared: every entry is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_unpool2x2.sv
// Streaming 2x2 max-unpooling: one pooled row in, two upsampled raster rows out.
// Optional MAX_UNPOOL_PINGPONG_EN overlaps filling the next row with emission of the current one.
module max_unpool2x2
  import max_unpool_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int IN_COLS = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [WIDTH-1:0] in_data_i,
  input  logic [1:0]              in_idx_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [WIDTH-1:0] out_data_o,
  output logic                    out_eol_o
);

  localparam int KW = $clog2(2 * IN_COLS);
  localparam int CW = KW - 1;
  localparam int EW = WIDTH + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(2 * IN_COLS - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0]  out_data_q, out_data_d;
  logic                     out_eol_q, out_eol_d;
  logic                     in_fire_s, out_fire_s, fill_done_s, start_s;
  logic                     load_s, bot_s;
  logic [KW-1:0]            nk_s;
  logic [EW-1:0]            rd_entry_s;
  logic [EW-1:0]            wr_entry_s;

  assign in_fire_s   = in_valid_i && in_ready_o;
  assign out_fire_s  = out_valid_q && out_ready_i;
  assign fill_done_s = in_fire_s && (col_q == COL_LAST);
  assign wr_entry_s  = {in_idx_i, in_data_i};

`ifdef MAX_UNPOOL_PINGPONG_EN
  logic          wr_sel_q, wr_sel_d, full_q, full_d, row_end_s, rd_sel_s;
  logic [EW-1:0] rd_a_s, rd_b_s;

  assign row_end_s  = out_fire_s && (state_q == EMIT_BOT) && (k_q == K_LAST);
  assign in_ready_o = !full_q;
  assign start_s    = (fill_done_s && ((state_q == FILL) || row_end_s)) || (full_q && row_end_s);
  // On a swap the freshly filled buffer is the one being read from this cycle.
  assign rd_sel_s   = start_s ? wr_sel_q : ~wr_sel_q;
  assign rd_entry_s = rd_sel_s ? rd_b_s : rd_a_s;

  unpool_row_buf #(.EW(EW), .DEPTH(IN_COLS), .AW(CW)) u_buf_a (
    .clk_i   (clk_i),
    .we_i    (in_fire_s && !wr_sel_q),
    .waddr_i (col_q),
    .wdata_i (wr_entry_s),
    .raddr_i (nk_s[KW-1:1]),
    .rdata_o (rd_a_s)
  );

  unpool_row_buf #(.EW(EW), .DEPTH(IN_COLS), .AW(CW)) u_buf_b (
    .clk_i   (clk_i),
    .we_i    (in_fire_s && wr_sel_q),
    .waddr_i (col_q),
    .wdata_i (wr_entry_s),
    .raddr_i (nk_s[KW-1:1]),
    .rdata_o (rd_b_s)
  );

  always_comb begin
    wr_sel_d = wr_sel_q;
    full_d   = full_q;
    if (start_s) begin
      wr_sel_d = ~wr_sel_q;
      full_d   = 1'b0;
    end else if (fill_done_s) begin
      full_d = 1'b1;
    end else begin
      full_d = full_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_sel_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      full_q   <= full_d;
    end
  end
`else
  assign in_ready_o = (state_q == FILL);
  assign start_s    = fill_done_s;

  unpool_row_buf #(.EW(EW), .DEPTH(IN_COLS), .AW(CW)) u_buf (
    .clk_i   (clk_i),
    .we_i    (in_fire_s),
    .waddr_i (col_q),
    .wdata_i (wr_entry_s),
    .raddr_i (nk_s[KW-1:1]),
    .rdata_o (rd_entry_s)
  );
`endif

  // k_q is the column of the pixel currently held in the output register.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    load_s  = 1'b0;
    bot_s   = 1'b0;
    nk_s    = {KW{1'b0}};
    col_d   = col_q;
    if (in_fire_s) begin
      col_d = (col_q == COL_LAST) ? {CW{1'b0}} : col_q + CW'(1);
    end else begin
      col_d = col_q;
    end
    case (state_q)
      FILL: begin
        if (start_s) begin
          state_d = EMIT_TOP;
          k_d     = {KW{1'b0}};
          load_s  = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
      EMIT_TOP: begin
        if (out_fire_s) begin
          load_s = 1'b1;
          if (k_q == K_LAST) begin
            state_d = EMIT_BOT;
            k_d     = {KW{1'b0}};
            bot_s   = 1'b1;
          end else begin
            k_d  = k_q + KW'(1);
            nk_s = k_q + KW'(1);
          end
        end else begin
          state_d = EMIT_TOP;
        end
      end
      EMIT_BOT: begin
        if (out_fire_s) begin
          if (k_q != K_LAST) begin
            load_s = 1'b1;
            bot_s  = 1'b1;
            k_d    = k_q + KW'(1);
            nk_s   = k_q + KW'(1);
          end else if (start_s) begin
            state_d = EMIT_TOP;
            k_d     = {KW{1'b0}};
            load_s  = 1'b1;
          end else begin
            state_d = FILL;
            k_d     = {KW{1'b0}};
          end
        end else begin
          state_d = EMIT_BOT;
        end
      end
      default: begin
        state_d = FILL;
        k_d     = {KW{1'b0}};
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_eol_d   = out_eol_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = idx_hit(rd_entry_s[EW-1:WIDTH], bot_s, nk_s[0]) ?
                    rd_entry_s[WIDTH-1:0] : {WIDTH{1'b0}};
      out_eol_d   = (nk_s == K_LAST);
    end else if (out_fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      col_q       <= {CW{1'b0}};
      k_q         <= {KW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eol_q   <= out_eol_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_eol_o   = out_eol_q;

endmodule

// File: tb/tb_max_unpool2x2.sv
// Scoreboard bench for max_unpool2x2 with IN_COLS=2; honours MAX_UNPOOL_PINGPONG_EN.
module tb_max_unpool2x2;

  localparam int WIDTH = 9;
  localparam int N     = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_idx = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_eol;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] mon_exp;

  max_unpool2x2 #(.WIDTH(WIDTH), .IN_COLS(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_idx_i    (in_idx),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_eol_o   (out_eol)
  );

  always #5 clk = ~clk;

  // Every output transfer is popped and compared against the model.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xfers++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h eol=%b required no transfer", out_data, out_eol);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_eol, out_data} !== mon_exp) begin
          errors++;
          $display("FAIL sb_pixel got data=%h eol=%b required data=%h eol=%b",
                   out_data, out_eol, mon_exp[WIDTH-1:0], mon_exp[WIDTH]);
        end
      end
    end
  end

  task automatic push_row(input logic [WIDTH-1:0] d0, input logic [1:0] i0,
                          input logic [WIDTH-1:0] d1, input logic [1:0] i1);
    logic [WIDTH-1:0] d[N];
    logic [1:0]       ix[N];
    d[0] = d0; d[1] = d1; ix[0] = i0; ix[1] = i1;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 2 * N; k++) begin
        logic [WIDTH-1:0] v;
        logic [1:0]       pos;
        pos = 2'(b * 2 + k % 2);
        v = (ix[k / 2] == pos) ? d[k / 2] : {WIDTH{1'b0}};
        exp_q.push_back({(k == 2 * N - 1), v});
      end
    end
  endtask

  task automatic send_pixel(input logic [WIDTH-1:0] d, input logic [1:0] i);
    int b;
    b = 0;
    in_data = d; in_idx = i; in_valid = 1'b1;
    while (!in_ready && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_row(input logic [WIDTH-1:0] d0, input logic [1:0] i0,
                          input logic [WIDTH-1:0] d1, input logic [1:0] i1);
    push_row(d0, i0, d1, i1);
    send_pixel(d0, i0);
    send_pixel(d1, i1);
  endtask

  task automatic wait_drain(input int want);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || out_valid) && b < 500) begin
      @(posedge clk); #1;
      b++;
    end
    checks++;
    if (exp_q.size() != 0 || xfers != want) begin
      errors++;
      $display("FAIL drain transfers=%0d left=%0d required transfers=%0d left=0", xfers, exp_q.size(), want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({out_valid, out_data, out_eol, in_ready} !== {1'b0, 9'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got valid=%b data=%h eol=%b ready=%b required 0 000 0 1",
               out_valid, out_data, out_eol, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    xfers = 0;
    send_row(9'd5, 2'b00, 9'h1FD, 2'b11);
    wait_drain(8);
  endtask

  task automatic test_backpressure();
    xfers = 0;
    send_row(9'd4, 2'b01, 9'h1FF, 2'b00);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_data, out_eol} !== {1'b1, 9'd4, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got valid=%b data=%h eol=%b required 1 004 0",
                 i, out_valid, out_data, out_eol);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    wait_drain(8);
  endtask

  task automatic test_reset_mid();
    send_row(9'd1, 2'b00, 9'd2, 2'b11);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_reset got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
    end
    exp_q.delete();
    rst = 1'b0;
    xfers = 0;
    send_row(9'd7, 2'b01, 9'd2, 2'b10);
    wait_drain(8);
  endtask

  task automatic test_inready_single();
    int cnt;
    cnt = 0;
    xfers = 0;
    send_row(9'd3, 2'b10, 9'd6, 2'b01);
    while (!in_ready && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL ready_low_cycles got %0d required 8", cnt);
    end
    wait_drain(8);
  endtask

  task automatic test_back_to_back();
    int b;
    xfers = 0;
    send_row(9'd11, 2'b11, 9'h180, 2'b00);
`ifdef MAX_UNPOOL_PINGPONG_EN
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pp_ready_during_emit got %b required 1", in_ready);
    end
`endif
    send_row(9'h0FF, 2'b01, 9'd9, 2'b10);
`ifdef MAX_UNPOOL_PINGPONG_EN
    b = 0;
    while (xfers < 16 && b < 100) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL pp_no_gap after %0d transfers got valid=%b required 1", xfers, out_valid);
      end
      @(posedge clk); #1;
      b++;
    end
`else
    b = 0;
`endif
    wait_drain(16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
`ifndef MAX_UNPOOL_PINGPONG_EN
    test_inready_single();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
